// File: rtl/flit_demux_wormhole.sv
// flit_demux_wormhole: 1-to-N wormhole flit demux with per-output FIFOs and drop flagging.
// Define FLIT_DEMUX_STATS_EN to add per-output saturating transfer counters.
module flit_demux_wormhole #(
  parameter int flitWidth  = 32,
  parameter int numOutputs = 4,
  parameter int selWidth   = 2,
  parameter int fifoDepth  = 2
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic [flitWidth-1:0]            inFlit,
  input  logic                            inHead,
  input  logic                            inTail,
  input  logic [selWidth-1:0]             inSelect,
  output logic [numOutputs-1:0]           outValid,
  input  logic [numOutputs-1:0]           outReady,
  output logic [numOutputs*flitWidth-1:0] outFlit,
  output logic                            errDrop,
  output logic                            locked
`ifdef FLIT_DEMUX_STATS_EN
  ,
  input  logic                            statClear,
  output logic [numOutputs*16-1:0]        statCount
`endif
);
  localparam int AW = $clog2(fifoDepth);
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUTE = 2'd1, S_DROP = 2'd2;
  logic [1:0] r_state;
  logic [selWidth-1:0] r_lock_port;
  logic r_err_drop, r_locked;
  logic [numOutputs-1:0] w_full, w_push, w_pop;
  logic [selWidth-1:0] w_port;
  logic [1:0] w_state_nxt;
  logic w_sel_ok, w_route, w_xfer;
  assign w_sel_ok = 32'(inSelect) < numOutputs;
  assign w_port   = r_state == S_ROUTE ? r_lock_port : inSelect;
  // w_route: this flit goes into a FIFO; every other accepted flit is dropped
  assign w_route  = r_state == S_ROUTE || (r_state == S_IDLE && inHead && w_sel_ok);
  assign inReady  = w_route ? !w_full[w_port] : 1'b1;
  assign w_xfer   = inValid && inReady;
  assign errDrop  = r_err_drop;
  assign locked   = r_locked;
  assign w_state_nxt = !w_xfer ? r_state :
                       r_state == S_IDLE ? (inHead && !inTail ? (w_sel_ok ? S_ROUTE : S_DROP) : S_IDLE) :
                       inTail ? S_IDLE : r_state;
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_lock_port <= '0;
      r_err_drop  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_locked   <= w_state_nxt != S_IDLE;
      r_err_drop <= w_xfer && !w_route;
      if (w_xfer && w_route && r_state == S_IDLE) r_lock_port <= inSelect;
    end
  end
  for (genvar k = 0; k < numOutputs; k++) begin : g_out
    logic [flitWidth-1:0] r_mem [fifoDepth];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    assign w_full[k]   = r_cnt == (AW+1)'(fifoDepth);
    assign w_push[k]   = w_xfer && w_route && w_port == selWidth'(k);
    assign w_pop[k]    = outValid[k] && outReady[k];
    assign outValid[k] = r_cnt != '0;
    assign outFlit[k*flitWidth +: flitWidth] = outValid[k] ? r_mem[r_rp] : '0;
    always_ff @(posedge clk) begin
      if (!resetN) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[k]) begin
          r_mem[r_wp] <= inFlit;
          r_wp        <= r_wp + 1'b1;
        end
        if (w_pop[k]) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (AW+1)'(w_push[k]) - (AW+1)'(w_pop[k]);
      end
    end
`ifdef FLIT_DEMUX_STATS_EN
    logic [15:0] r_stat;
    always_ff @(posedge clk) begin
      if (!resetN || statClear) r_stat <= '0;
      else if (w_pop[k] && r_stat != 16'hFFFF) r_stat <= r_stat + 1'b1;
    end
    assign statCount[k*16 +: 16] = r_stat;
`endif
  end
endmodule

// File: tb/tb_flit_demux_wormhole.sv
// tb_flit_demux_wormhole: vector table, directed sequences and random traffic vs. a queue-based model.
module tb_flit_demux_wormhole;
  localparam int FW = 32, N = 3, SW = 2, D = 2;
  localparam int M_IDLE = 0, M_ROUTE = 1, M_DROP = 2;
  logic clk = 1'b0, resetN = 1'b0, inValid = 1'b0, inHead = 1'b0, inTail = 1'b0;
  logic inReady, errDrop, locked;
  logic [FW-1:0] inFlit = '0;
  logic [SW-1:0] inSelect = '0;
  logic [N-1:0] outValid, outReady = '0;
  logic [N*FW-1:0] outFlit;
  logic clr_next = 1'b0;
`ifdef FLIT_DEMUX_STATS_EN
  logic statClear = 1'b0;
  logic [N*16-1:0] statCount;
  int m_stat [N];
`endif
  flit_demux_wormhole #(.flitWidth(FW), .numOutputs(N), .selWidth(SW), .fifoDepth(D)) dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady), .inFlit(inFlit),
    .inHead(inHead), .inTail(inTail), .inSelect(inSelect), .outValid(outValid),
    .outReady(outReady), .outFlit(outFlit), .errDrop(errDrop), .locked(locked)
`ifdef FLIT_DEMUX_STATS_EN
    , .statClear(statClear), .statCount(statCount)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [FW-1:0] q [N][$];
  int m_mode = M_IDLE, m_port = 0;
  logic m_err = 1'b0, m_known = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: per-output queues of flits still owed, packet mode, and the pending drop flag.
  task automatic model_step();
    logic rt, rdy, x;
    int p;
    rt = 1'b0;
    p = 0;
    if (m_mode == M_ROUTE) begin rt = 1'b1; p = m_port; end
    else if (m_mode == M_IDLE && inHead && int'(inSelect) < N) begin rt = 1'b1; p = int'(inSelect); end
    rdy = rt ? (q[p].size() < D) : 1'b1;
    if (m_known) begin
      for (int k = 0; k < N; k++) begin
        chk("out_valid", 64'(outValid[k]), 64'(q[k].size() != 0));
        if (q[k].size() != 0) chk("out_flit", 64'(outFlit[k*FW +: FW]), 64'(q[k][0]));
`ifdef FLIT_DEMUX_STATS_EN
        chk("stat_count", 64'(statCount[k*16 +: 16]), 64'(m_stat[k]));
`endif
      end
      chk("in_ready", 64'(inReady), 64'(rdy));
      chk("err_drop", 64'(errDrop), 64'(m_err));
      chk("locked", 64'(locked), 64'(m_mode != M_IDLE));
    end
    if (!resetN) begin
      for (int k = 0; k < N; k++) begin
        q[k].delete();
`ifdef FLIT_DEMUX_STATS_EN
        m_stat[k] = 0;
`endif
      end
      m_mode = M_IDLE; m_port = 0; m_err = 1'b0; m_known = 1'b1;
      return;
    end
    for (int k = 0; k < N; k++) begin
`ifdef FLIT_DEMUX_STATS_EN
      if (statClear) m_stat[k] = 0;
      else if (q[k].size() != 0 && outReady[k] && m_stat[k] < 65535) m_stat[k]++;
`endif
      if (q[k].size() != 0 && outReady[k]) void'(q[k].pop_front());
    end
    x = inValid && rdy;
    m_err = x && !rt;
    if (x) begin
      if (rt) begin q[p].push_back(inFlit); m_port = p; end
      if (m_mode == M_IDLE) begin
        if (inHead && !inTail) m_mode = rt ? M_ROUTE : M_DROP;
      end else if (inTail) m_mode = M_IDLE;
    end
  endtask
  task automatic cyc(input logic rn, input logic v, input logic h, input logic t, input int sel,
                     input logic [FW-1:0] f, input logic [N-1:0] r);
    @(posedge clk);
    #1;
    resetN = rn; inValid = v; inHead = h; inTail = t; inSelect = sel[SW-1:0]; inFlit = f; outReady = r;
`ifdef FLIT_DEMUX_STATS_EN
    statClear = clr_next;
`endif
    @(negedge clk);
    model_step();
  endtask
  typedef struct {
    logic rn, v, h, t;
    int sel;
    logic [FW-1:0] f;
    logic [N-1:0] r, ev;
    logic erdy, eerr, elock;
    logic [FW-1:0] ef2;
  } vec_t;
  vec_t tbl [10];
  initial begin
    tbl[0] = '{1, 1, 1, 1, 2, 32'hA5A5_0001, 3'b000, 3'b000, 1, 0, 0, 32'h0};
    tbl[1] = '{1, 0, 0, 0, 0, 32'h0,         3'b000, 3'b100, 1, 0, 0, 32'hA5A5_0001};
    tbl[2] = '{1, 0, 0, 0, 0, 32'h0,         3'b100, 3'b100, 1, 0, 0, 32'hA5A5_0001};
    tbl[3] = '{1, 1, 1, 0, 3, 32'h11,        3'b000, 3'b000, 1, 0, 0, 32'h0};
    tbl[4] = '{1, 1, 0, 0, 0, 32'h12,        3'b000, 3'b000, 1, 1, 1, 32'h0};
    tbl[5] = '{1, 1, 0, 1, 0, 32'h13,        3'b000, 3'b000, 1, 1, 1, 32'h0};
    tbl[6] = '{1, 0, 0, 0, 0, 32'h0,         3'b000, 3'b000, 1, 1, 0, 32'h0};
    tbl[7] = '{1, 1, 0, 0, 1, 32'h14,        3'b000, 3'b000, 1, 0, 0, 32'h0};
    tbl[8] = '{1, 0, 0, 0, 0, 32'h0,         3'b000, 3'b000, 1, 1, 0, 32'h0};
    tbl[9] = '{1, 0, 0, 0, 0, 32'h0,         3'b000, 3'b000, 1, 0, 0, 32'h0};
    cyc(0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("rst_out_valid", 64'(outValid), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_err_drop", 64'(errDrop), 64'(0));
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rn, tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].sel, tbl[i].f, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), 64'(outValid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(inReady), 64'(tbl[i].erdy));
      chk($sformatf("vec%0d_err", i), 64'(errDrop), 64'(tbl[i].eerr));
      chk($sformatf("vec%0d_locked", i), 64'(locked), 64'(tbl[i].elock));
      if (tbl[i].ev[2]) chk($sformatf("vec%0d_flit2", i), 64'(outFlit[95:64]), 64'(tbl[i].ef2));
    end
    // wormhole: later inSelect values must be ignored
    cyc(1, 1, 1, 0, 1, 32'hB001, '1);
    chk("worm_locked0", 64'(locked), 64'(0));
    cyc(1, 1, 0, 0, 3, 32'hB002, '1);
    chk("worm_locked1", 64'(locked), 64'(1));
    chk("worm_valid1", 64'(outValid), 64'(3'b010));
    chk("worm_flit1", 64'(outFlit[63:32]), 64'(32'hB001));
    cyc(1, 1, 0, 1, 0, 32'hB003, '1);
    chk("worm_valid2", 64'(outValid), 64'(3'b010));
    chk("worm_flit2", 64'(outFlit[63:32]), 64'(32'hB002));
    cyc(1, 0, 0, 0, 0, 0, '1);
    chk("worm_flit3", 64'(outFlit[63:32]), 64'(32'hB003));
    chk("worm_unlocked", 64'(locked), 64'(0));
    cyc(1, 0, 0, 0, 0, 0, '1);
    chk("worm_empty", 64'(outValid), 64'(0));
    // backpressure on output 1, then an independent packet to output 0
    cyc(1, 1, 1, 0, 1, 32'hC000, 3'b000);
    chk("bp_rdy0", 64'(inReady), 64'(1));
    cyc(1, 1, 0, 0, 0, 32'hC001, 3'b000);
    chk("bp_rdy1", 64'(inReady), 64'(1));
    cyc(1, 1, 0, 0, 0, 32'hC002, 3'b000);
    chk("bp_full", 64'(inReady), 64'(0));
    cyc(1, 1, 0, 0, 0, 32'hC002, 3'b010);
    chk("bp_full_pop", 64'(inReady), 64'(0));
    cyc(1, 1, 0, 0, 0, 32'hC002, 3'b010);
    chk("bp_resume", 64'(inReady), 64'(1));
    cyc(1, 1, 0, 1, 0, 32'hC003, 3'b010);
    chk("bp_tail", 64'(inReady), 64'(1));
    cyc(1, 1, 1, 1, 0, 32'hD000, 3'b010);
    chk("bp_other_port", 64'(inReady), 64'(1));
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, '1);
    chk("bp_drained", 64'(outValid), 64'(0));
    // streaming with simultaneous push and pop on output 0
    cyc(1, 1, 1, 0, 0, 32'hE000, 3'b001);
    for (int i = 1; i < 7; i++) begin
      cyc(1, 1, 0, i == 6, 0, 32'hE000 + i, 3'b001);
      chk("stream_rdy", 64'(inReady), 64'(1));
      chk("stream_valid", 64'(outValid), 64'(3'b001));
    end
    cyc(1, 0, 0, 0, 0, 0, 3'b001);
    // reset in the middle of a packet
    cyc(1, 1, 1, 0, 1, 32'hF000, 3'b000);
    cyc(1, 1, 0, 0, 0, 32'hF001, 3'b000);
    cyc(0, 1, 0, 0, 0, 32'hF002, 3'b000);
    cyc(1, 1, 0, 0, 0, 32'hF003, 3'b000);
    chk("midrst_valid", 64'(outValid), 64'(0));
    chk("midrst_locked", 64'(locked), 64'(0));
    cyc(1, 0, 0, 0, 0, 0, 3'b000);
    chk("midrst_body_drop", 64'(errDrop), 64'(1));
    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
          int'($urandom % 4), $urandom, N'($urandom));
`ifdef FLIT_DEMUX_STATS_EN
    clr_next = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, '1);
    clr_next = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 2, 32'h5000 + i, '1);
    cyc(1, 0, 0, 0, 0, 0, '1);
    cyc(1, 0, 0, 0, 0, 0, '1);
    chk("stat_five", 64'(statCount[47:32]), 64'(5));
    cyc(1, 1, 1, 1, 2, 32'h5100, '1);
    clr_next = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, '1);
    clr_next = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, '1);
    chk("stat_clear", 64'(statCount[47:32]), 64'(0));
    for (int i = 0; i < 65540; i++) cyc(1, 1, 1, 1, 2, i, '1);
    cyc(1, 0, 0, 0, 0, 0, '1);
    cyc(1, 0, 0, 0, 0, 0, '1);
    chk("stat_sat", 64'(statCount[47:32]), 64'(16'hFFFF));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
